// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared constants for the CIC decimator integrator and comb
//                blocks: default data width, stage count, decimation factor,
//                differential delay and the derived phase-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int DEF_WIDTH      = 26;
    localparam int DEF_STAGES     = 3;
    localparam int DEF_RATE       = 32;
    localparam int DEF_DIFF_DELAY = 1;

    // Width of the decimation phase counter for the default rate
    localparam int PH_W = $clog2(DEF_RATE);

endpackage
`default_nettype wire

// File: rtl/comb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : comb_stage
//  Description : One CIC comb differentiator, dout = din - din[k-DIFF_DELAY].
//                The delay line advances only when shift is asserted, so it
//                runs at the decimated rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_stage #(
    parameter int WIDTH      = 26,
    parameter int DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dly_q [DIFF_DELAY];

    // Delay line: newest decimated sample enters at index 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_q[i] <= '0;
            end
        end else if (shift) begin
            dly_q[0] <= din;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Modulo 2^WIDTH difference; wrap-around is what keeps the CIC exact
    assign dout = din - dly_q[DIFF_DELAY-1];

endmodule
`default_nettype wire

// File: rtl/cic_comb_decim.sv
`default_nettype none
// ============================================================================
//  Module      : cic_comb_decim
//  Description : Decimating comb section of a CIC decimator. Keeps one input
//                sample in every RATE accepted samples and passes it through
//                STAGES cascaded comb differentiators, registering the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int STAGES     = DEF_STAGES,
    parameter int RATE       = DEF_RATE,
    parameter int DIFF_DELAY = DEF_DIFF_DELAY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         x_in,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         y_out,
    output logic [$clog2(RATE)-1:0]  phase
);

    localparam int            PW      = $clog2(RATE);
    localparam logic [PW-1:0] PH_LAST = PW'(RATE - 1);

    logic [PW-1:0]    phase_q;
    logic [PW-1:0]    phase_d;
    logic             w_strobe;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;

    // The strobe is the last accepted sample of each decimation frame
    assign w_strobe = in_valid && (phase_q == PH_LAST);

    // Phase advances only on accepted samples and wraps after RATE-1
    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    // Phase counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Comb cascade, evaluated combinationally within the strobe cycle
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] w_dout;

        if (s == 0) begin : g_first
            assign w_din = x_in;
        end else begin : g_next
            assign w_din = g_stage[s-1].w_dout;
        end

        comb_stage #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .shift (w_strobe),
            .din   (w_din),
            .dout  (w_dout)
        );
    end

    assign w_result = g_stage[STAGES-1].w_dout;

    // Output register: capture the chain result on the strobe, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= w_strobe;
            if (w_strobe) begin
                y_q <= w_result;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign phase     = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_comb_decim.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_comb_decim
//  Description : Self-checking bench for cic_comb_decim. Three configurations
//                (N=1/M=1, N=2/M=1, N=3/M=2) share one stimulus stream and are
//                compared against a closed-form binomial CIC comb model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_comb_decim;

    localparam int W = 26;
    localparam int R = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  x_in = '0;

    logic          ov1, ov2, ov3;
    logic [W-1:0]  y1, y2, y3;
    logic [4:0]    ph1, ph2, ph3;

    int total = 0;
    int bad   = 0;

    // Model state: accepted-sample count since reset and captured samples
    int            acc = 0;
    logic [W-1:0]  dq[$];
    logic [W-1:0]  ey1 = '0, ey2 = '0, ey3 = '0;
    int            pulses = 0;

    always #5 clk = ~clk;

    cic_comb_decim #(.WIDTH(W), .STAGES(1), .RATE(R), .DIFF_DELAY(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .out_valid(ov1), .y_out(y1), .phase(ph1));

    cic_comb_decim #(.WIDTH(W), .STAGES(2), .RATE(R), .DIFF_DELAY(1)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .out_valid(ov2), .y_out(y2), .phase(ph2));

    cic_comb_decim #(.WIDTH(W), .STAGES(3), .RATE(R), .DIFF_DELAY(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .out_valid(ov3), .y_out(y3), .phase(ph3));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // N cascaded M-delay differences == sum_j (-1)^j C(N,j) d[k-jM], mod 2^W
    function automatic logic [W-1:0] model_y(input int n, input int m);
        longint s = 0;
        int     last = dq.size() - 1;
        for (int j = 0; j <= n; j++) begin
            int idx = last - j * m;
            if (idx >= 0) begin
                if (j % 2 == 0) s = s + binom(n, j) * longint'(dq[idx]);
                else            s = s - binom(n, j) * longint'(dq[idx]);
            end
        end
        return s[W-1:0];
    endfunction

    // Apply one input cycle, update the model, then check all outputs after the edge
    task automatic step(input logic v, input logic [W-1:0] x);
        logic strb;
        in_valid = v;
        x_in     = x;
        strb     = v && (acc % R == R - 1);
        if (strb) begin
            dq.push_back(x);
            ey1 = model_y(1, 1);
            ey2 = model_y(2, 1);
            ey3 = model_y(3, 2);
            pulses++;
        end
        if (v) acc++;
        @(posedge clk);
        #1;
        check("ov1", 32'(ov1), 32'(strb));
        check("ov2", 32'(ov2), 32'(strb));
        check("ov3", 32'(ov3), 32'(strb));
        check("y1", 32'(y1), 32'(ey1));
        check("y2", 32'(y2), 32'(ey2));
        check("y3", 32'(y3), 32'(ey3));
        check("phase", 32'(ph1), 32'(acc % R));
        check("phase3", 32'(ph3), 32'(acc % R));
    endtask

    // Asynchronous reset between edges; outputs must clear immediately
    task automatic hard_reset();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        dq.delete();
        acc = 0; pulses = 0;
        ey1 = '0; ey2 = '0; ey3 = '0;
        check("rst_y1", 32'(y1), 32'd0);
        check("rst_y3", 32'(y3), 32'd0);
        check("rst_ov", 32'({ov1, ov2, ov3}), 32'd0);
        check("rst_ph", 32'(ph1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset state
        @(posedge clk);
        #1;
        check("init_y2", 32'(y2), 32'd0);
        check("init_ov", 32'({ov1, ov2, ov3}), 32'd0);
        check("init_ph", 32'(ph2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ramp x=n every cycle
        for (int n = 0; n < 200; n++) step(1'b1, W'(n));
        check("ramp_pulses", 32'(pulses), 32'd6);
        check("ramp_y1", 32'(y1), 32'd32);
        check("ramp_y2", 32'(y2), 32'd0);

        // Wrap across one decimated pair
        hard_reset();
        for (int n = 0; n < 31; n++) step(1'b1, '0);
        step(1'b1, 26'h3FFFFF0);
        for (int n = 0; n < 31; n++) step(1'b1, '0);
        step(1'b1, 26'h0000010);
        check("wrap_y1", 32'(y1), 32'h20);

        // Ramp of accepted samples with random in_valid gaps
        hard_reset();
        begin
            int n = 0;
            for (int c = 0; c < 600; c++) begin
                logic v = 1'($urandom_range(0, 1));
                step(v, W'(n));
                if (v) n++;
            end
        end
        if (pulses > 1) check("gap_y1", 32'(y1), 32'd32);

        // Reset mid-frame at phase 17; first output afterwards is the raw sample
        for (int c = 0; c < 200 && (acc % R) != 17; c++) step(1'b1, W'($urandom));
        check("pre_rst_ph", 32'(ph1), 32'd17);
        hard_reset();
        begin
            logic [W-1:0] raw = W'($urandom);
            for (int n = 0; n < 31; n++) step(1'b1, W'($urandom));
            step(1'b1, raw);
            check("post_rst_y3", 32'(y3), 32'(raw));
            check("post_rst_y2", 32'(y2), 32'(raw));
        end

        // Random data with gaps, including start-up transient
        hard_reset();
        for (int c = 0; c < 12000; c++) step(($urandom_range(0, 3) != 0), W'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
